// File: rtl/nibble_serial_adder.sv
// ============================================================================
// Module   : nibble_serial_adder
// Brief    : WIDTH-bit adder that runs one nibble per cycle through one 4-bit ripple adder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, next_state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] op_a, op_b, partial;
  logic [3:0]       add_sum;
  logic             add_carry;
  logic             accept;

  rippleAdder_4bit u_adder (
    .A     (op_a[3:0]),
    .B     (op_b[3:0]),
    .cin   (carry),
    .sum   (add_sum),
    .carry (add_carry)
  );

  assign ready  = (state == IDLE) || (state == DONE);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign accept = start && ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (cnt == LAST) next_state = DONE;
      DONE:    next_state = start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Sum nibbles enter partial from the top so nibble 0 lands at the bottom after NIB steps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      carry   <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      partial <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      carry <= cin;
      op_a  <= a;
      op_b  <= b;
    end else if (state == RUN) begin
      partial <= {add_sum, partial[WIDTH-1:4]};
      op_a    <= {4'b0, op_a[WIDTH-1:4]};
      op_b    <= {4'b0, op_b[WIDTH-1:4]};
      carry   <= add_carry;
      cnt     <= cnt + 1'b1;
      if (cnt == LAST) begin
        sum  <= {add_sum, partial[WIDTH-1:4]};
        cout <= add_carry;
      end
    end
  end

endmodule

// ============================================================================
// Module   : rippleAdder_4bit
// Brief    : 4-bit ripple-carry adder built from full-adder cells.
// Revision : 1.0
// ============================================================================
module rippleAdder_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       carry
);

  logic [4:0] c;

  assign c[0]  = cin;
  assign carry = c[4];

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]  = A[i] ^ B[i] ^ c[i];
    assign c[i+1]  = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
// ============================================================================
// Module   : tb_nibble_serial_adder
// Brief    : Directed vector table plus hand-written handshake and reset sequences.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        cin;
  logic        ready, busy, done, cout;
  logic [15:0] sum;

  int checks   = 0;
  int failures = 0;
  logic [15:0] last_sum = 16'h0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  vec_t vecs[12];

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                        input logic [15:0] es, input logic ec);
    int n;
    @(negedge clk);
    a = ta; b = tb_; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    check("sum_held_in_run", 32'(sum), 32'(last_sum));
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'd5);
    check("sum", 32'(sum), 32'(es));
    check("cout", 32'(cout), 32'(ec));
    @(negedge clk);
    check("done_width", 32'(done), 32'd0);
    check("ready_idle", 32'(ready), 32'd1);
    last_sum = es;
  endtask

  initial begin
    int n;
    logic [15:0] ra, rb;
    logic        rc;
    logic [16:0] full;

    vecs[0]  = '{16'h1234, 16'h5678, 1'b0, 16'h68AC, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2]  = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1};
    vecs[3]  = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vecs[4]  = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
    vecs[5]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[6]  = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};
    vecs[7]  = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};
    vecs[8]  = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[9]  = '{16'h1234, 16'hEDCB, 1'b0, 16'hFFFF, 1'b0};
    vecs[10] = '{16'h9999, 16'h6667, 1'b0, 16'h0000, 1'b1};
    vecs[11] = '{16'h00F0, 16'h0F10, 1'b0, 16'h1000, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_sum",   32'(sum),   32'd0);
    check("rst_cout",  32'(cout),  32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout);

    // Second start during RUN is ignored; start held in DONE chains back-to-back.
    @(negedge clk);
    a = 16'h0F0F; b = 16'h00F1; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    n = 3;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ignore_latency", 32'(n), 32'd5);
    check("ignore_sum", 32'(sum), 32'h1000);
    check("ignore_cout", 32'(cout), 32'd0);
    start = 1'b1; a = 16'h0001; b = 16'h0001; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_done_low", 32'(done), 32'd0);
    check("b2b_sum_held", 32'(sum), 32'h1000);
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b_latency", 32'(n), 32'd5);
    check("b2b_sum", 32'(sum), 32'h0002);
    check("b2b_cout", 32'(cout), 32'd0);
    @(negedge clk);
    check("b2b_done_width", 32'(done), 32'd0);

    // Reset in the second RUN cycle aborts the operation.
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy",  32'(busy),  32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_sum",   32'(sum),   32'd0);
    check("abort_cout",  32'(cout),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) n++;
    end
    check("abort_no_done", 32'(n), 32'd0);
    last_sum = 16'h0;
    run_op(16'h1234, 16'h5678, 1'b0, 16'h68AC, 1'b0);

    for (int i = 0; i < 150; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
      run_op(ra, rb, rc, full[15:0], full[16]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
